// File: rtl/nested_loop_seq.sv
// -----------------------------------------------------------------------------
// nested_loop_seq
//
// Nested-loop sequencer for a datapath. A host first holds `load` (LOAD phase,
// all write channels enabled), then issues `start` from ARMED. The run sweeps
// an outer index i = 0..i_max and, for each i, an inner index j = 0..j_max.
// Bounds and the write mask are captured on start, so the host may change them
// freely while the run is in progress.
//
// Per outer pass the sequencer spends one cycle in INIT (inner reset), j_max+1
// cycles in INNER (datapath body) and one cycle in OUTER (inner reset, outer
// step). A completed run ends with a single DONE cycle that pulses `done`.
//
// Ports
//   clk_in   in   clock
//   reset    in   synchronous active-high reset
//   load     in   host load request
//   start    in   run request (honoured in ARMED only)
//   abort    in   cancel a run (honoured in INIT/INNER/OUTER only)
//   i_max    in   last outer index, captured on start
//   j_max    in   last inner index, captured on start
//   wr_mask  in   write-channel enables for the run, captured on start
//   i        out  current outer index
//   j        out  current inner index
//   reset_j  out  inner-reset strobe (INIT and OUTER)
//   en       out  registered clock enable, high while in INIT or INNER
//   clk      out  gated datapath clock
//   wr       out  write enables
//   busy     out  run in progress
//   done     out  one-cycle run-complete pulse
// -----------------------------------------------------------------------------
module nested_loop_seq #(
    parameter int I_W  = 4,
    parameter int J_W  = 3,
    parameter int N_WR = 2
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            load,
    input  logic            start,
    input  logic            abort,
    input  logic [I_W-1:0]  i_max,
    input  logic [J_W-1:0]  j_max,
    input  logic [N_WR-1:0] wr_mask,
    output logic [I_W-1:0]  i,
    output logic [J_W-1:0]  j,
    output logic            reset_j,
    output logic            en,
    output logic            clk,
    output logic [N_WR-1:0] wr,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_INIT  = 3'd3,
        S_INNER = 3'd4,
        S_OUTER = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [I_W-1:0]  i_q, i_d;
    logic [J_W-1:0]  j_q, j_d;
    logic [I_W-1:0]  i_max_q, i_max_d;
    logic [J_W-1:0]  j_max_q, j_max_d;
    logic [N_WR-1:0] wr_mask_q, wr_mask_d;
    logic            en_q;
    logic            en_latch_q;
    logic            in_run;

    assign in_run = (state_q == S_INIT) || (state_q == S_INNER) || (state_q == S_OUTER);

    // ------------------------------------------------------------------ state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            i_max_q   <= '0;
            j_max_q   <= '0;
            wr_mask_q <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            i_max_q   <= i_max_d;
            j_max_q   <= j_max_d;
            wr_mask_q <= wr_mask_d;
            // en is decoded from the next state so it is already high during
            // the first INIT cycle and drops in the cycle after the last INNER.
            en_q      <= (state_d == S_INIT) || (state_d == S_INNER);
        end
    end

    // ------------------------------------------------------------------ next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = S_LOAD;
            S_LOAD:  if (!load) state_d = S_ARMED;
            S_ARMED: begin
                if (load)       state_d = S_LOAD;
                else if (start) state_d = S_INIT;
            end
            S_INIT:  state_d = S_INNER;
            S_INNER: if (j_q == j_max_q) state_d = S_OUTER;
            S_OUTER: state_d = (i_q == i_max_q) ? S_DONE : S_INIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every other transition, but only inside a run.
        if (abort && in_run) state_d = S_IDLE;
    end

    // ------------------------------------------------------------------ counters and capture
    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        i_max_d   = i_max_q;
        j_max_d   = j_max_q;
        wr_mask_d = wr_mask_q;
        case (state_q)
            S_ARMED: begin
                if (!load && start) begin
                    i_max_d   = i_max;
                    j_max_d   = j_max;
                    wr_mask_d = wr_mask;
                    i_d       = '0;
                end
            end
            S_INIT:  j_d = '0;
            // Bound compare precedes the increment, so neither counter wraps.
            S_INNER: if (j_q != j_max_q) j_d = j_q + J_W'(1);
            S_OUTER: if (i_q != i_max_q) i_d = i_q + I_W'(1);
            default: ;
        endcase
        if (abort && in_run) begin
            i_d = '0;
            j_d = '0;
        end
    end

    // ------------------------------------------------------------------ output decode
    always_comb begin
        wr      = '0;
        reset_j = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_LOAD:  wr = '1;
            S_INIT: begin
                reset_j = 1'b1;
                wr      = wr_mask_q;
                busy    = 1'b1;
            end
            S_INNER: begin
                wr   = wr_mask_q;
                busy = 1'b1;
            end
            S_OUTER: begin
                reset_j = 1'b1;
                wr      = wr_mask_q;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ glitch-free gate
    // The enable is only allowed to change while clk_in is low, so the AND
    // below can never produce a shortened high pulse.
    always_latch begin
        if (!clk_in) en_latch_q <= en_q;
    end

    assign clk = clk_in & en_latch_q;
    assign en  = en_q;
    assign i   = i_q;
    assign j   = j_q;

endmodule

// File: doc/nested_loop_seq.md
# nested_loop_seq

Parametrised nested-loop sequencer that drives a datapath through a load phase and then an outer/inner iteration sweep. It owns its own loop counters, and the inner and outer bounds are programmed at run start. It produces a glitch-free gated clock for the datapath, N_WR write-enable channels with a run-time mask, and a busy/done/abort handshake for the host controller.

## Interface
- I_W, 4: outer counter width; i_max range 0..2^I_W-1
- J_W, 3: inner counter width; j_max range 0..2^J_W-1
- N_WR, 2: number of write-enable channels
- clk_in  in  1  clock
- reset  in  1  reset, synchronous, active-high
- load  in  1  host load request
- start  in  1  run request, sampled in ARMED only
- abort  in  1  cancel a run in progress
- i_max  in  I_W  last outer index, captured on start
- j_max  in  J_W  last inner index, captured on start
- wr_mask  in  N_WR  channel enables for the run, captured on start
- i  out  I_W  current outer index
- j  out  J_W  current inner index
- reset_j  out  1  inner-reset strobe to datapath
- en  out  1  registered clock-enable
- clk  out  1  gated clock = clk_in & latched en
- wr  out  N_WR  write enables
- busy  out  1  run in progress
- done  out  1  one-cycle run-complete pulse

## Operation
- States: IDLE, LOAD, ARMED, INIT, INNER, OUTER, DONE.
- IDLE: load=1 -> LOAD.
- LOAD: while load=1, stay in LOAD; load=0 -> ARMED.
- ARMED:
  - load=1 -> LOAD.
  - else start=1 -> INIT; capture i_max_r, j_max_r, wr_mask_r; i<=0.
- INIT: j<=0 -> INNER.
- INNER: j==j_max_r -> OUTER, j holds; else j<=j+1.
- OUTER:
  - i==i_max_r -> DONE.
  - else i<=i+1 -> INIT.
- DONE: -> IDLE unconditionally.
- abort=1 in INIT, INNER or OUTER -> IDLE next cycle, i<=0, j<=0, no done pulse. abort is ignored in other states. abort has priority over every other transition.
- Iteration counts:
  - Inner body runs j_max+1 cycles per pass (j=0..j_max).
  - Outer runs i_max+1 passes.
  - No counter wraps; the bound compare always precedes the increment.
- Outputs by state:
  - IDLE: all 0.
  - LOAD: wr = all ones; everything else 0.
  - ARMED: all 0.
  - INIT: reset_j=1, wr=wr_mask_r, busy=1.
  - INNER: wr=wr_mask_r, busy=1.
  - OUTER: reset_j=1, wr=wr_mask_r, busy=1.
  - DONE: done=1; everything else 0.
- en: a flop loaded from the next-state decode. en=1 exactly during cycles spent in INIT or INNER.
- clk: en passes through a latch transparent while clk_in=0, then is ANDed with clk_in. clk must never glitch.

## Timing
- Reset (synchronous): state=IDLE; i=0, j=0; wr=0, reset_j=0, en=0, busy=0, done=0; captured registers cleared; the latch output clears on the next clk_in low phase.
- A reset mid-run overrides abort and all transitions; the outputs above hold from the next edge.
- start->busy latency: 1 cycle (start sampled at edge k, busy=1 after edge k).
- Busy duration: (i_max+1)*(j_max+3) cycles.
- done is asserted the cycle after the final OUTER and lasts exactly 1 cycle.
- Gated clk delivers (i_max+1)*(j_max+2) rising edges per completed run.
- i_max, j_max and wr_mask may change freely after capture without affecting the run.
- start outside ARMED and load during a run are ignored.

## Test plan
- Reset, then load=1 for 3 cycles, load=0, start with i_max=2, j_max=3, wr_mask=2'b10 -> wr=2'b11 for 3 LOAD cycles; busy for 18 cycles; 15 gated clk edges; wr=2'b10 while busy; i sequence 0,1,2; one done pulse; return to IDLE.
- i_max=0, j_max=0 -> INIT, INNER, OUTER, DONE; busy 3 cycles; 2 clk edges; reset_j high in INIT and OUTER.
- i_max=15, j_max=7 (full range) -> no wrap; final i=15, j=7; busy=160 cycles.
- abort asserted in 4th INNER cycle of pass 1 -> IDLE next cycle; i=j=0; no done; clk stops with no runt pulse.
- start asserted in IDLE and LOAD -> ignored. load during ARMED -> back to LOAD. abort together with load in ARMED -> LOAD.
- reset asserted in OUTER with abort=1 -> all outputs at reset values after the edge; a subsequent full run behaves identically to the first scenario.
